// File: rtl/hamming_clc_decoder_pkg.sv
// Shared types for the CLC Hamming receive path: FSM states, row status codes
// and the syndrome-to-bit location table.
package hamming_clc_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROW  = 2'd1,
    ST_COL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] STAT_OK     = 2'b00;
  localparam logic [1:0] STAT_SINGLE = 2'b01;
  localparam logic [1:0] STAT_DOUBLE = 2'b10;

  localparam int ROWS = 4;

  // Zero syndrome maps to the q bit, so a lone q error is fixed by the same path.
  function automatic logic [2:0] syn_to_bit(input logic [2:0] syn);
    logic [2:0] loc;
    case (syn)
      3'd6:    loc = 3'd0;
      3'd5:    loc = 3'd1;
      3'd3:    loc = 3'd2;
      3'd7:    loc = 3'd3;
      3'd1:    loc = 3'd4;
      3'd2:    loc = 3'd5;
      3'd4:    loc = 3'd6;
      default: loc = 3'd7;
    endcase
    return loc;
  endfunction

endpackage

// File: rtl/hamming_clc_decoder_if.sv
// Word-in / result-out handshake bundle between the APB wrapper and the decoder.
interface hamming_clc_decoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [0:39] code_in;
  logic        out_valid;
  logic        out_ready;
  logic [0:15] data_out;
  logic        err_corr;
  logic        err_uncorr;
  logic        col_err;
  logic [0:7]  row_stat;

  modport master (
    output in_valid, code_in, out_ready,
    input  in_ready, out_valid, data_out, err_corr, err_uncorr, col_err, row_stat
  );

  modport slave (
    input  in_valid, code_in, out_ready,
    output in_ready, out_valid, data_out, err_corr, err_uncorr, col_err, row_stat
  );
endinterface

// File: rtl/hamming_row_dec.sv
// Combinational SEC-DED decoder for one 8-bit row (d0 d1 d2 d3 p0 p1 p2 q).
module hamming_row_dec
  import hamming_clc_decoder_pkg::*;
(
  input  logic [0:7] row_in,
  output logic [0:7] row_out,
  output logic [2:0] syn,
  output logic       q_chk,
  output logic [1:0] stat
);

  logic [2:0] loc;

  assign syn[0] = row_in[4] ^ row_in[1] ^ row_in[2] ^ row_in[3];
  assign syn[1] = row_in[5] ^ row_in[0] ^ row_in[2] ^ row_in[3];
  assign syn[2] = row_in[6] ^ row_in[0] ^ row_in[1] ^ row_in[3];
  assign q_chk  = ^row_in;
  assign loc    = syn_to_bit(syn);

  always_comb begin
    row_out = row_in;
    stat    = STAT_OK;
    if (q_chk) begin
      row_out[loc] = ~row_in[loc];
      stat         = STAT_SINGLE;
    end else if (syn != 3'd0) begin
      stat = STAT_DOUBLE;
    end
  end

endmodule

// File: rtl/hamming_clc_decoder.sv
// CLC Hamming receive decoder: row-serial SEC-DED over four rows, then column check.
// Build option CLC_COLFIX_EN enables column-parity-assisted repair of one double-error row.
module hamming_clc_decoder
  import hamming_clc_decoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  hamming_clc_decoder_if.slave bus,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic [CNT_W-1:0]     uncorr_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t      state;
  logic [1:0]  row_idx;
  logic [0:39] word;

  logic [0:7]  dec_row;
  logic [2:0]  dec_syn;
  logic        dec_q;
  logic [1:0]  dec_stat;
  logic        dec_unused;

  logic [0:7]  col_m;
  logic [0:15] payload;
  logic        any_dbl;
  logic        any_sgl;

  hamming_row_dec u_row_dec (
    .row_in  (word[{row_idx, 3'b000} +: 8]),
    .row_out (dec_row),
    .syn     (dec_syn),
    .q_chk   (dec_q),
    .stat    (dec_stat)
  );

  // Syndrome and overall check are already folded into dec_stat.
  assign dec_unused   = ^{dec_syn, dec_q};
  assign bus.in_ready = (state == ST_IDLE);

  always_comb begin
    col_m   = word[32:39];
    payload = '0;
    any_dbl = 1'b0;
    any_sgl = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      col_m            = col_m ^ word[8*r +: 8];
      payload[4*r +: 4] = word[8*r +: 4];
      if (bus.row_stat[2*r +: 2] == STAT_DOUBLE) any_dbl = 1'b1;
      if (bus.row_stat[2*r +: 2] == STAT_SINGLE) any_sgl = 1'b1;
    end
  end

`ifdef CLC_COLFIX_EN
  logic [2:0] dbl_cnt;
  logic [1:0] dbl_row;
  logic       fix_hit;

  always_comb begin
    dbl_cnt = 3'd0;
    dbl_row = 2'd0;
    for (int r = 0; r < ROWS; r++) begin
      if (bus.row_stat[2*r +: 2] == STAT_DOUBLE) begin
        dbl_cnt = dbl_cnt + 3'd1;
        dbl_row = r[1:0];
      end
    end
    fix_hit = (dbl_cnt == 3'd1) && ($countones(col_m) == 2);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      row_idx        <= 2'd0;
      word           <= '0;
      bus.out_valid  <= 1'b0;
      bus.data_out   <= '0;
      bus.row_stat   <= '0;
      bus.err_corr   <= 1'b0;
      bus.err_uncorr <= 1'b0;
      bus.col_err    <= 1'b0;
      corr_cnt       <= '0;
      uncorr_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            word    <= bus.code_in;
            row_idx <= 2'd0;
            state   <= ST_ROW;
          end
        end
        ST_ROW: begin
          word[{row_idx, 3'b000} +: 8]  <= dec_row;
          bus.row_stat[{row_idx, 1'b0} +: 2] <= dec_stat;
          if (row_idx == 2'd3) state <= ST_COL;
          else                 row_idx <= row_idx + 2'd1;
        end
        ST_COL: begin
          bus.col_err <= |col_m;
`ifdef CLC_COLFIX_EN
          if (fix_hit) begin
            word[{dbl_row, 3'b000} +: 8]  <= word[{dbl_row, 3'b000} +: 8] ^ col_m;
            bus.row_stat[{dbl_row, 1'b0} +: 2] <= STAT_SINGLE;
            bus.col_err <= 1'b0;
          end
`endif
          state <= ST_DONE;
        end
        ST_DONE: begin
          if (!bus.out_valid) begin
            bus.out_valid  <= 1'b1;
            bus.data_out   <= payload;
            bus.err_uncorr <= any_dbl;
            bus.err_corr   <= any_sgl;
          end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= ST_IDLE;
            if (bus.err_corr && !bus.err_uncorr && (corr_cnt != '1))
              corr_cnt <= corr_cnt + CNT_ONE;
            if (bus.err_uncorr && (uncorr_cnt != '1))
              uncorr_cnt <= uncorr_cnt + CNT_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // Placed last so a clear overrides any increment in the same cycle.
      if (clr_cnt) begin
        corr_cnt   <= '0;
        uncorr_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_hamming_clc_decoder.sv
// Scoreboard bench for hamming_clc_decoder; CLC_COLFIX_EN selects the matching expectations.
module tb_hamming_clc_decoder;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  typedef struct {
    logic [15:0] data;
    logic        corr;
    logic        uncorr;
    logic        col;
    logic [7:0]  rs;
  } exp_t;

  logic clk;
  logic rst;
  logic clr_cnt;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;

  hamming_clc_decoder_if bus ();

  hamming_clc_decoder #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_cnt    (clr_cnt),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  logic [CW-1:0] m_corr = '0;
  logic [CW-1:0] m_unc  = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] d, input logic c, input logic u,
                              input logic col, input logic [7:0] rs);
    exp_t e;
    e.data = d; e.corr = c; e.uncorr = u; e.col = col; e.rs = rs;
    return e;
  endfunction

  function automatic logic [0:39] flip2(input logic [0:39] base, input int a, input int b);
    logic [0:39] w;
    w = base;
    if (a >= 0) w[a] = ~w[a];
    if (b >= 0) w[b] = ~w[b];
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got output %0h expected none", bus.data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_out",   64'(bus.data_out),   64'(e.data));
        chk("err_corr",   64'(bus.err_corr),   64'(e.corr));
        chk("err_uncorr", 64'(bus.err_uncorr), 64'(e.uncorr));
        chk("col_err",    64'(bus.col_err),    64'(e.col));
        chk("row_stat",   64'(bus.row_stat),   64'(e.rs));
      end
    end
  end

  task automatic send(input logic [0:39] code, input exp_t e, input bit stall, input bit clr);
    int n;
    bus.code_in  = code;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
    if (stall) bus.out_ready = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 64'(n), 64'd6);
    if (stall) begin
      repeat (3) begin
        @(posedge clk); #1;
        chk("stall_valid",    64'(bus.out_valid), 64'd1);
        chk("stall_in_ready", 64'(bus.in_ready),  64'd0);
        chk("stall_data",     64'(bus.data_out),  64'(e.data));
        chk("stall_row_stat", 64'(bus.row_stat),  64'(e.rs));
      end
      bus.out_ready = 1'b1;
    end
    if (clr) clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("valid_drop", 64'(bus.out_valid), 64'd0);
    chk("idle_ready", 64'(bus.in_ready),  64'd1);
    if (clr) begin
      m_corr = '0;
      m_unc  = '0;
    end else begin
      if (e.corr && !e.uncorr && m_corr != CMAX) m_corr = m_corr + 1'b1;
      if (e.uncorr && m_unc != CMAX)             m_unc  = m_unc + 1'b1;
    end
    chk("corr_cnt",   64'(corr_cnt),   64'(m_corr));
    chk("uncorr_cnt", 64'(uncorr_cnt), 64'(m_unc));
  endtask

  initial begin
    logic [0:39] zero_w;
    logic [0:39] clean_w;
    logic [0:39] t2_w;
    exp_t t2_e;

    zero_w  = '0;
    clean_w = 40'hAA6600FF33;
    t2_w    = flip2(zero_w, 9, -1);
    t2_e    = mk(16'h0000, 1'b1, 1'b0, 1'b0, 8'b00010000);

    rst = 1'b1; clr_cnt = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.code_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_data",      64'(bus.data_out),  64'd0);
    chk("rst_row_stat",  64'(bus.row_stat),  64'd0);
    chk("rst_flags",     64'({bus.err_corr, bus.err_uncorr, bus.col_err}), 64'd0);
    chk("rst_cnts",      64'({corr_cnt, uncorr_cnt}), 64'd0);

    send(40'hFFFFFFFF00, mk(16'hFFFF, 1'b0, 1'b0, 1'b0, 8'h00), 1'b0, 1'b0);
    send(t2_w, t2_e, 1'b0, 1'b0);
`ifdef CLC_COLFIX_EN
    send(flip2(zero_w, 0, 1), mk(16'h0000, 1'b1, 1'b0, 1'b0, 8'b01000000), 1'b0, 1'b0);
`else
    send(flip2(zero_w, 0, 1), mk(16'hC000, 1'b0, 1'b1, 1'b1, 8'b10000000), 1'b0, 1'b0);
`endif
    send(flip2(zero_w, 35, -1), mk(16'h0000, 1'b0, 1'b0, 1'b1, 8'h00), 1'b0, 1'b0);
    send(clean_w, mk(16'hA60F, 1'b0, 1'b0, 1'b0, 8'h00), 1'b0, 1'b0);
    send(flip2(clean_w, 7, 30), mk(16'hA60F, 1'b1, 1'b0, 1'b0, 8'b01000001), 1'b0, 1'b0);
    send(t2_w, t2_e, 1'b1, 1'b0);

    // Abort a word mid-decode; it must vanish without producing a result.
    bus.code_in  = t2_w;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_corr = '0;
    m_unc  = '0;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("midrst_data",      64'(bus.data_out),  64'd0);
    chk("midrst_row_stat",  64'(bus.row_stat),  64'd0);
    chk("midrst_cnts",      64'({corr_cnt, uncorr_cnt}), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_output", 64'(bus.out_valid), 64'd0);

    for (int i = 0; i < 17; i++) send(t2_w, t2_e, 1'b0, 1'b0);
    chk("sat_corr_cnt", 64'(corr_cnt), 64'(CMAX));
    send(t2_w, t2_e, 1'b0, 1'b1);
    chk("clr_corr_cnt", 64'(corr_cnt), 64'd0);

    repeat (2) @(posedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
